// File: rtl/bist_sig_checker_pkg.sv
// Shared BIST checker definitions: state encodings, default parameters and result flags.
// The same values are used by the BIST controller and the pattern generator.
package bist_sig_checker_pkg;

  localparam int          DEF_DATA_W     = 8;
  localparam int          DEF_CNT_W      = 16;
  localparam int          DEF_NCLOCK     = 650;
  localparam logic [7:0]  DEF_MISR_POLY  = 8'h1D;
  localparam logic [7:0]  DEF_MISR_SEED  = 8'h00;
  localparam logic [7:0]  DEF_GOLDEN_SIG = 8'h00;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_COMPACT = 3'd2;
  localparam logic [2:0] ST_EVAL    = 3'd3;
  localparam logic [2:0] ST_RESULT  = 3'd4;

  typedef struct packed {
    logic done;
    logic pass;
    logic fail;
    logic cycle_err;
  } res_t;

endpackage

// File: rtl/bist_sig_checker_if.sv
// Controller strobes, CUT response and status bus of the BIST signature checker.
interface bist_sig_checker_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              init;
  logic              running;
  logic              finish;
  logic [DATA_W-1:0] cut_out;
  logic [DATA_W-1:0] signature;
  logic [CNT_W-1:0]  run_cnt;
  logic              done;
  logic              pass;
  logic              fail;
  logic              cycle_err;
  logic              timeout;

  modport master (
    output init, running, finish, cut_out,
    input  signature, run_cnt, done, pass, fail, cycle_err, timeout
  );

  modport slave (
    input  init, running, finish, cut_out,
    output signature, run_cnt, done, pass, fail, cycle_err, timeout
  );
endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift left, fold the MSB back through POLY, XOR data in.
module bist_misr
  import bist_sig_checker_pkg::*;
#(
  parameter int                DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] POLY   = DEF_MISR_POLY,
  parameter logic [DATA_W-1:0] SEED   = DEF_MISR_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] sig_o
);

  logic [DATA_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear_i)
      sig_d = SEED;
    else if (en_i)
      sig_d = {sig_q[DATA_W-2:0], 1'b0} ^ (sig_q[DATA_W-1] ? POLY : '0) ^ data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sig_q <= SEED;
    else       sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/bist_sig_checker.sv
// BIST response checker: compacts CUT outputs while running, then grades signature and run length.
// Optional watchdog forcing evaluation after 2*NCLOCK armed cycles: define SIG_TIMEOUT_EN.
module bist_sig_checker
  import bist_sig_checker_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                NCLOCK     = DEF_NCLOCK,
  parameter int                CNT_W      = DEF_CNT_W,
  parameter logic [DATA_W-1:0] MISR_POLY  = DEF_MISR_POLY,
  parameter logic [DATA_W-1:0] MISR_SEED  = DEF_MISR_SEED,
  parameter logic [DATA_W-1:0] GOLDEN_SIG = DEF_GOLDEN_SIG
) (
  input  logic              clk,
  input  logic              reset,
  bist_sig_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] NCLK_C = CNT_W'(NCLOCK);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  res_t              res_q, res_d;
  logic              misr_clr, misr_en, eval_ok;
  logic              collecting, tmo_fire, tmo_flag;
  logic [DATA_W-1:0] sig;

  assign collecting = (state_q == ST_ARMED) || (state_q == ST_COMPACT);

`ifdef SIG_TIMEOUT_EN
  localparam int              WD_W     = CNT_W + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(2 * NCLOCK - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            tmo_q, tmo_d;

  // Fires on the edge where the watchdog would reach 2*NCLOCK; finish still wins.
  assign tmo_fire = collecting && (wd_q == WD_LIMIT);

  always_comb begin
    wd_d  = wd_q;
    tmo_d = tmo_q;
    if (bus.init) begin
      wd_d  = '0;
      tmo_d = 1'b0;
    end else if (collecting) begin
      wd_d = wd_q + 1'b1;
      if (!bus.finish && tmo_fire) tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end

  assign tmo_flag    = tmo_q;
  assign bus.timeout = tmo_q;
`else
  assign tmo_fire    = 1'b0;
  assign tmo_flag    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    eval_ok  = (sig == GOLDEN_SIG) && (cnt_q == NCLK_C) && !tmo_flag;
    if (bus.init) begin
      state_d  = ST_ARMED;
      cnt_d    = '0;
      res_d    = '0;
      misr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_ARMED, ST_COMPACT: begin
          // The word presented with finish (or a watchdog trip) is never compacted.
          if (bus.finish || tmo_fire) begin
            state_d = ST_EVAL;
          end else if (bus.running) begin
            misr_en = 1'b1;
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            state_d = ST_COMPACT;
          end
        end
        ST_EVAL: begin
          res_d.done      = 1'b1;
          res_d.pass      = eval_ok;
          res_d.fail      = !eval_ok;
          res_d.cycle_err = (cnt_q != NCLK_C);
          state_d         = ST_RESULT;
        end
        ST_IDLE, ST_RESULT: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  bist_misr #(
    .DATA_W (DATA_W),
    .POLY   (MISR_POLY),
    .SEED   (MISR_SEED)
  ) u_misr (
    .clk     (clk),
    .reset   (reset),
    .clear_i (misr_clr),
    .en_i    (misr_en),
    .data_i  (bus.cut_out),
    .sig_o   (sig)
  );

  assign bus.signature = sig;
  assign bus.run_cnt   = cnt_q;
  assign bus.done      = res_q.done;
  assign bus.pass      = res_q.pass;
  assign bus.fail      = res_q.fail;
  assign bus.cycle_err = res_q.cycle_err;

endmodule

// File: tb/tb_bist_sig_checker.sv
// Drives two checkers (NCLOCK=4/GOLDEN=0F and defaults) with identical strobes and grades
// both against a reference model built on GF(2) polynomial arithmetic.
module tb_bist_sig_checker;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic init_s = 1'b0, run_s = 1'b0, fin_s = 1'b0;
  logic [7:0] cut_s = '0;
  int nerr = 0, nchk = 0;

  always #5 clk = ~clk;

  bist_sig_checker_if #(.DATA_W(8), .CNT_W(16)) ifa ();
  bist_sig_checker_if #(.DATA_W(8), .CNT_W(16)) ifb ();

  assign ifa.init = init_s;  assign ifa.running = run_s;
  assign ifa.finish = fin_s; assign ifa.cut_out = cut_s;
  assign ifb.init = init_s;  assign ifb.running = run_s;
  assign ifb.finish = fin_s; assign ifb.cut_out = cut_s;

  bist_sig_checker #(.NCLOCK(4), .GOLDEN_SIG(8'h0F)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  bist_sig_checker dut_b (.clk(clk), .reset(reset), .bus(ifb));

  logic [7:0]  o_sig[2];
  logic [15:0] o_cnt[2];
  logic        o_done[2], o_pass[2], o_fail[2], o_cerr[2], o_tmo[2];
  assign o_sig[0] = ifa.signature; assign o_sig[1] = ifb.signature;
  assign o_cnt[0] = ifa.run_cnt;   assign o_cnt[1] = ifb.run_cnt;
  assign o_done[0] = ifa.done;     assign o_done[1] = ifb.done;
  assign o_pass[0] = ifa.pass;     assign o_pass[1] = ifb.pass;
  assign o_fail[0] = ifa.fail;     assign o_fail[1] = ifb.fail;
  assign o_cerr[0] = ifa.cycle_err; assign o_cerr[1] = ifb.cycle_err;
  assign o_tmo[0] = ifa.timeout;   assign o_tmo[1] = ifb.timeout;

  // Reference model: per instance, "collecting" between init and finish, then one cycle later graded.
  int          NCLK[2] = '{4, 650};
  logic [7:0]  GOLD[2] = '{8'h0F, 8'h00};
  logic        m_act[2], m_pend[2], m_done[2], m_pass[2], m_fail[2], m_cerr[2], m_tmo[2];
  logic [7:0]  m_sig[2];
  logic [15:0] m_cnt[2];
  int          m_wd[2];

  // s(x)*x mod (x^8+x^4+x^3+x^2+1), plus the new word
  function automatic logic [7:0] gf_fold(input logic [7:0] s, input logic [7:0] d);
    logic [8:0] t;
    t = {s, 1'b0};
    if (t[8]) t = t ^ 9'h11D;
    return t[7:0] ^ d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_pend[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_fail[i] = 0;
      m_cerr[i] = 0; m_tmo[i] = 0; m_sig[i] = 8'h00; m_cnt[i] = 0; m_wd[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (init_s) begin
        m_act[i] = 1; m_pend[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_fail[i] = 0;
        m_cerr[i] = 0; m_tmo[i] = 0; m_sig[i] = 8'h00; m_cnt[i] = 0; m_wd[i] = 0;
      end else if (m_pend[i]) begin
        m_pend[i] = 0;
        m_done[i] = 1;
        m_cerr[i] = (int'(m_cnt[i]) != NCLK[i]);
        m_pass[i] = (m_sig[i] == GOLD[i]) && !m_cerr[i] && !m_tmo[i];
        m_fail[i] = !m_pass[i];
      end else if (m_act[i]) begin
        if (fin_s) begin
          m_pend[i] = 1; m_act[i] = 0;
        end
`ifdef SIG_TIMEOUT_EN
        else if (m_wd[i] + 1 == 2 * NCLK[i]) begin
          m_pend[i] = 1; m_act[i] = 0; m_tmo[i] = 1;
        end
`endif
        else begin
          if (run_s) begin
            m_sig[i] = gf_fold(m_sig[i], cut_s);
            if (m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
          end
          m_wd[i]++;
        end
      end
    end
  endtask

  // Called at a negedge; returns at the next negedge after the model has seen the posedge.
  task automatic cyc(input logic i, input logic r, input logic f, input logic [7:0] c);
    init_s = i; run_s = r; fin_s = f; cut_s = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if ({o_sig[i], o_cnt[i], o_done[i], o_pass[i], o_fail[i], o_cerr[i], o_tmo[i]} !== 29'd0) begin
        nerr++;
        $display("FAIL reset_state inst%0d: got sig=%h cnt=%0d flags=%b%b%b%b%b want all 0", i,
                 o_sig[i], o_cnt[i], o_done[i], o_pass[i], o_fail[i], o_cerr[i], o_tmo[i]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_golden_pass();
    cyc(1, 0, 0, 8'h00);
    repeat (4) cyc(0, 1, 0, 8'h01);
    cyc(0, 0, 1, 8'h00);
    nchk++;
    if (o_done[0] !== 1'b0 || o_sig[0] !== 8'h0F || o_cnt[0] !== 16'd4) begin
      nerr++;
      $display("FAIL golden_pre_done: got done=%b sig=%h cnt=%0d want 0/0f/4", o_done[0], o_sig[0], o_cnt[0]);
    end
    cyc(0, 0, 0, 8'h00);
    nchk++;
    if ({o_done[0], o_pass[0], o_fail[0], o_cerr[0]} !== 4'b1100) begin
      nerr++;
      $display("FAIL golden_result: got done/pass/fail/cerr=%b%b%b%b want 1100",
               o_done[0], o_pass[0], o_fail[0], o_cerr[0]);
    end
  endtask

  task automatic test_short_run();
    cyc(1, 0, 0, 8'h00);
    repeat (3) cyc(0, 1, 0, 8'h01);
    cyc(0, 0, 1, 8'h00);
    cyc(0, 0, 0, 8'h00);
    nchk++;
    if (o_sig[0] !== 8'h07 || {o_done[0], o_pass[0], o_fail[0], o_cerr[0]} !== 4'b1011) begin
      nerr++;
      $display("FAIL short_run: got sig=%h done/pass/fail/cerr=%b%b%b%b want 07 1011",
               o_sig[0], o_done[0], o_pass[0], o_fail[0], o_cerr[0]);
    end
  endtask

  task automatic test_full_run();
    logic [31:0] snap;
    cyc(1, 0, 0, 8'h00);
    repeat (650) cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 1, 8'h00);
    cyc(0, 0, 0, 8'h00);
    nchk++;
    if (o_sig[1] !== 8'h00 || o_cnt[1] !== 16'd650 || o_pass[1] !== 1'b1 || o_fail[1] !== 1'b0) begin
      nerr++;
      $display("FAIL full_run: got sig=%h cnt=%0d pass=%b fail=%b want 00 650 1 0",
               o_sig[1], o_cnt[1], o_pass[1], o_fail[1]);
    end
    snap = {o_sig[1], o_cnt[1], o_done[1], o_pass[1], o_fail[1], o_cerr[1], 4'd0};
    cyc(0, 1, 1, 8'h5A);
    cyc(0, 1, 0, 8'h33);
    cyc(0, 0, 0, 8'h00);
    nchk++;
    if ({o_sig[1], o_cnt[1], o_done[1], o_pass[1], o_fail[1], o_cerr[1], 4'd0} !== snap) begin
      nerr++;
      $display("FAIL result_frozen: got sig=%h cnt=%0d done=%b pass=%b want unchanged %h",
               o_sig[1], o_cnt[1], o_done[1], o_pass[1], snap);
    end
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 0, 8'h00);
    for (int k = 0; k < 50; k++) cyc(0, 1, 0, 8'($urandom));
    #2 reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if ({o_sig[i], o_cnt[i], o_done[i], o_pass[i], o_fail[i], o_cerr[i], o_tmo[i]} !== 29'd0) begin
        nerr++;
        $display("FAIL async_reset inst%0d: got sig=%h cnt=%0d done=%b want all 0", i,
                 o_sig[i], o_cnt[i], o_done[i]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) cyc(0, 1, 0, 8'hA5);
    cyc(0, 1, 1, 8'hA5);
    cyc(0, 0, 0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (o_cnt[i] !== 16'd0 || o_sig[i] !== 8'h00 || o_done[i] !== 1'b0) begin
        nerr++;
        $display("FAIL idle_ignores inst%0d: got cnt=%0d sig=%h done=%b want 0 00 0", i,
                 o_cnt[i], o_sig[i], o_done[i]);
      end
    end
  endtask

  task automatic test_same_edge();
    cyc(1, 0, 0, 8'h00);
    repeat (3) cyc(0, 1, 0, 8'h01);
    cyc(0, 1, 1, 8'h01);
    cyc(0, 0, 0, 8'h00);
    nchk++;
    if (o_cnt[0] !== 16'd3 || o_sig[0] !== 8'h07 || o_fail[0] !== 1'b1 || o_done[0] !== 1'b1) begin
      nerr++;
      $display("FAIL same_edge: got cnt=%0d sig=%h fail=%b done=%b want 3 07 1 1",
               o_cnt[0], o_sig[0], o_fail[0], o_done[0]);
    end
  endtask

  task automatic test_timeout();
    cyc(1, 0, 0, 8'h00);
    repeat (12) cyc(0, 1, 0, 8'($urandom));
    nchk++;
`ifdef SIG_TIMEOUT_EN
    if ({o_tmo[0], o_done[0], o_fail[0], o_pass[0]} !== 4'b1110) begin
      nerr++;
      $display("FAIL timeout_fire: got tmo/done/fail/pass=%b%b%b%b want 1110",
               o_tmo[0], o_done[0], o_fail[0], o_pass[0]);
    end
`else
    if ({o_tmo[0], o_done[0]} !== 2'b00) begin
      nerr++;
      $display("FAIL timeout_absent: got tmo=%b done=%b want 0 0", o_tmo[0], o_done[0]);
    end
`endif
    nchk++;
    if (o_tmo[0] !== m_tmo[0] || o_cnt[0] !== m_cnt[0] || o_sig[0] !== m_sig[0]) begin
      nerr++;
      $display("FAIL timeout_model: got tmo=%b cnt=%0d sig=%h want %b %0d %h",
               o_tmo[0], o_cnt[0], o_sig[0], m_tmo[0], m_cnt[0], m_sig[0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int unsigned len;
      logic        easy;
      len  = $urandom_range(2, 6);
      easy = ($urandom_range(0, 1) == 1);
      cyc(1, 0, 0, 8'h00);
      for (int k = 0; k < int'(len); k++) begin
        logic r;
        r = ($urandom_range(0, 3) != 0);
        cyc(0, r, 0, easy ? 8'h01 : 8'($urandom));
        for (int i = 0; i < 2; i++) begin
          nchk++;
          if (o_sig[i] !== m_sig[i] || o_cnt[i] !== m_cnt[i]) begin
            nerr++;
            $display("FAIL rand_midrun it%0d inst%0d: got sig=%h cnt=%0d want %h %0d", it, i,
                     o_sig[i], o_cnt[i], m_sig[i], m_cnt[i]);
          end
        end
      end
      cyc(0, $urandom_range(0, 1) == 1, 1, 8'($urandom));
      cyc(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
      cyc(0, 1, 1, 8'($urandom));
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (o_sig[i] !== m_sig[i] || o_cnt[i] !== m_cnt[i] || o_done[i] !== m_done[i] ||
            o_pass[i] !== m_pass[i] || o_fail[i] !== m_fail[i] || o_cerr[i] !== m_cerr[i] ||
            o_tmo[i] !== m_tmo[i]) begin
          nerr++;
          $display("FAIL rand_result it%0d inst%0d: got sig=%h cnt=%0d dpfct=%b%b%b%b%b want %h %0d %b%b%b%b%b",
                   it, i, o_sig[i], o_cnt[i], o_done[i], o_pass[i], o_fail[i], o_cerr[i], o_tmo[i],
                   m_sig[i], m_cnt[i], m_done[i], m_pass[i], m_fail[i], m_cerr[i], m_tmo[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_golden_pass();
    test_short_run();
    test_full_run();
    test_async_reset();
    test_same_edge();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
